// File: rtl/dircc_mem_arbiter_if.sv
// Requester-side and downstream Avalon-MM signals of the arbiter.
// master: arbiter view; slave: requesters plus memory view.
interface dircc_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         m_address;
    logic                      m_read;
    logic                      m_write;
    logic [DATA_W-1:0]         m_writedata;
    logic                      m_waitrequest;
    logic [DATA_W-1:0]         m_readdata;
    logic                      m_readdatavalid;

    modport master (
        input  req_address, req_read, req_write, req_writedata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output m_address, m_read, m_write, m_writedata
    );

    modport slave (
        output req_address, req_read, req_write, req_writedata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  m_address, m_read, m_write, m_writedata
    );
endinterface

// File: rtl/dircc_mem_arbiter.sv
// Round-robin N:1 Avalon-MM arbiter, one transaction in flight,
// with read-data timeout and per-requester sticky error flags.
module dircc_mem_arbiter #(
    parameter int                NUM_REQ  = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    dircc_mem_arbiter_if.master  bus,
    output logic [NUM_REQ-1:0]   err_sticky,
    input  logic                 err_clear,
    output logic                 busy,
    output logic [2:0]           grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;

    state_e              state_q;
    logic [IW-1:0]       rr_q;
    logic [IW-1:0]       win_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                m_rd_q;
    logic                m_wr_q;
    logic [15:0]         cnt_q;
    logic [NUM_REQ-1:0]  rdv_q;
    logic [NUM_REQ-1:0]  err_q;

    logic [NUM_REQ-1:0]  act;
    logic [NUM_REQ-1:0]  act_rot;
    logic [IW:0]         sum;
    logic [IW-1:0]       pick;
    logic                found;
    logic                acc;
    logic [ADDR_W-1:0]   addr_a [NUM_REQ];
    logic [DATA_W-1:0]   wdat_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = bus.req_address[g*ADDR_W +: ADDR_W];
        assign wdat_a[g] = bus.req_writedata[g*DATA_W +: DATA_W];
    end

    // Rotate so bit 0 is rr_q, then take the lowest active offset.
    always_comb begin
        act     = bus.req_read | bus.req_write;
        act_rot = NUM_REQ'({act, act} >> rr_q);
        found   = 1'b0;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (act_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_q} + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(NUM_REQ)) begin
            pick = IW'(sum - (IW+1)'(NUM_REQ));
        end else begin
            pick = sum[IW-1:0];
        end
    end

    assign acc = (state_q == ISSUE) && !bus.m_waitrequest;

    always_comb begin
        bus.req_waitrequest = '1;
        if (acc) begin
            bus.req_waitrequest[win_q] = 1'b0;
        end
    end

    assign bus.m_address         = addr_q;
    assign bus.m_writedata       = wdata_q;
    assign bus.m_read            = m_rd_q;
    assign bus.m_write           = m_wr_q;
    assign bus.req_readdata      = rdata_q;
    assign bus.req_readdatavalid = rdv_q;
    assign err_sticky            = err_q;
    assign busy                  = (state_q != IDLE);
    assign grant_id              = 3'(win_q);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            m_rd_q  <= 1'b0;
            m_wr_q  <= 1'b0;
            cnt_q   <= '0;
            rdv_q   <= '0;
            err_q   <= '0;
        end else begin
            rdv_q <= '0;
            // A timeout below overrides the clear for its own bit.
            if (err_clear) begin
                err_q <= '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        win_q   <= pick;
                        addr_q  <= addr_a[pick];
                        wdata_q <= wdat_a[pick];
                        m_wr_q  <= bus.req_write[pick];
                        m_rd_q  <= !bus.req_write[pick];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.m_waitrequest) begin
                        m_rd_q  <= 1'b0;
                        m_wr_q  <= 1'b0;
                        rr_q    <= (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= m_wr_q ? IDLE : RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (bus.m_readdatavalid) begin
                        rdata_q        <= bus.m_readdata;
                        rdv_q[win_q]   <= 1'b1;
                        state_q        <= IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q        <= ERR_DATA;
                        rdv_q[win_q]   <= 1'b1;
                        err_q[win_q]   <= 1'b1;
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dircc_mem_arbiter.sv
// Random requesters and memory against a transaction-level model
// of the round-robin arbiter, plus a mid-issue reset scenario.
module tb_dircc_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam int P_FREE = 0;
    localparam int P_CMD  = 1;
    localparam int P_DATA = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         err_clear;
    logic [N-1:0] err_sticky;
    logic         busy;
    logic [2:0]   grant_id;

    dircc_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dircc_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .bus(bus),
        .err_sticky(err_sticky),
        .err_clear(err_clear),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit [N-1:0]  act, cr, cw;
    logic [31:0] ca [N];
    logic [31:0] cd [N];
    bit          force_read;

    int          ph, ph_now, w_m, rr_m, gid_m, kk, dd;
    bit          wr_m;
    logic [31:0] a_m, d_m, rdata_m;
    bit [N-1:0]  rdv_exp, err_m;
    bit          hit;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_cmd(input int i);
        int op;
        op    = force_read ? 0 : int'($urandom_range(0, 2));
        act[i] = 1'b1;
        cr[i]  = (op != 1);
        cw[i]  = (op != 0);
        ca[i]  = $urandom;
        cd[i]  = $urandom;
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return TO;
        if (r == 1) return TO + 1 + int'($urandom_range(0, 4));
        return int'($urandom_range(1, TO - 1));
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!act[i] && $urandom_range(0, 2) == 0) new_cmd(i);
        end
        for (int i = 0; i < N; i++) begin
            bus.req_read[i]  = act[i] & cr[i];
            bus.req_write[i] = act[i] & cw[i];
            bus.req_address[i*AW +: AW]   = ca[i];
            bus.req_writedata[i*DW +: DW] = cd[i];
        end
        bus.m_waitrequest = ($urandom_range(0, 1) == 1);
        bus.m_readdata    = $urandom;
        if (ph == P_DATA) bus.m_readdatavalid = (kk + 1 == dd);
        else bus.m_readdatavalid = ($urandom_range(0, 5) == 0);
        err_clear = ($urandom_range(0, 15) == 0);
    endtask

    task automatic check_outputs();
        bit [N-1:0] wr_exp;
        wr_exp = '1;
        if (ph == P_CMD && !bus.m_waitrequest) wr_exp[w_m] = 1'b0;
        chk("busy", 64'(busy), 64'(ph != P_FREE));
        chk("grant_id", 64'(grant_id), 64'(gid_m));
        chk("m_read", 64'(bus.m_read), 64'(ph == P_CMD && !wr_m));
        chk("m_write", 64'(bus.m_write), 64'(ph == P_CMD && wr_m));
        if (ph == P_CMD) begin
            chk("m_address", 64'(bus.m_address), 64'(a_m));
            chk("m_writedata", 64'(bus.m_writedata), 64'(d_m));
        end
        chk("waitrequest", 64'(bus.req_waitrequest), 64'(wr_exp));
        chk("readdatavalid", 64'(bus.req_readdatavalid), 64'(rdv_exp));
        chk("readdata", 64'(bus.req_readdata), 64'(rdata_m));
        chk("err_sticky", 64'(err_sticky), 64'(err_m));
    endtask

    task automatic model_update();
        bit [N-1:0] e_nx;
        e_nx    = err_clear ? '0 : err_m;
        rdv_exp = '0;
        case (ph)
            P_FREE: begin
                if (act != 0) begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (act[(rr_m + k) % N]) w_m = (rr_m + k) % N;
                    end
                    wr_m  = cw[w_m];
                    a_m   = ca[w_m];
                    d_m   = cd[w_m];
                    gid_m = w_m;
                    ph    = P_CMD;
                end
            end
            P_CMD: begin
                if (!bus.m_waitrequest) begin
                    rr_m     = (w_m + 1) % N;
                    act[w_m] = 1'b0;
                    if (wr_m) ph = P_FREE;
                    else begin
                        ph = P_DATA;
                        kk = 0;
                        dd = pick_delay();
                    end
                end
            end
            P_DATA: begin
                kk++;
                if (bus.m_readdatavalid) begin
                    rdata_m      = bus.m_readdata;
                    rdv_exp[w_m] = 1'b1;
                    ph           = P_FREE;
                end else if (kk == TO) begin
                    rdata_m      = ERR;
                    rdv_exp[w_m] = 1'b1;
                    e_nx[w_m]    = 1'b1;
                    ph           = P_FREE;
                end
            end
            default: ;
        endcase
        err_m = e_nx;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        ph_now = ph;
        check_outputs();
        model_update();
    endtask

    task automatic model_reset();
        ph = P_FREE; rr_m = 0; gid_m = 0; w_m = 0; kk = 0; dd = 0;
        wr_m = 1'b0; a_m = '0; d_m = '0; rdata_m = '0;
        rdv_exp = '0; err_m = '0;
    endtask

    initial begin
        rst = 1'b1;
        err_clear = 1'b0;
        bus.req_address = '0;
        bus.req_read = '0;
        bus.req_write = '0;
        bus.req_writedata = '0;
        bus.m_waitrequest = 1'b0;
        bus.m_readdata = '0;
        bus.m_readdatavalid = 1'b0;
        act = '0; cr = '0; cw = '0;
        for (int i = 0; i < N; i++) begin
            ca[i] = '0;
            cd[i] = '0;
        end
        force_read = 1'b0;
        hit = 1'b0;
        model_reset();

        #2;
        check_outputs();
        chk("rst_m_address", 64'(bus.m_address), 64'(0));
        chk("rst_m_writedata", 64'(bus.m_writedata), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        repeat (3000) step();

        force_read = 1'b1;
        for (int t = 0; t < 500 && !hit; t++) begin
            step();
            if (ph_now == P_CMD && !wr_m && bus.m_waitrequest) hit = 1'b1;
        end
        chk("rst_setup_reached", 64'(hit), 64'(1));
        if (hit) begin
            rst = 1'b1;
            #1;
            chk("rst_mid_m_read", 64'(bus.m_read), 64'(0));
            chk("rst_mid_waitreq", 64'(bus.req_waitrequest), 64'(4'hF));
            chk("rst_mid_busy", 64'(busy), 64'(0));
            chk("rst_mid_rdv", 64'(bus.req_readdatavalid), 64'(0));
            chk("rst_mid_grant", 64'(grant_id), 64'(0));
            chk("rst_mid_addr", 64'(bus.m_address), 64'(0));
            chk("rst_mid_rdata", 64'(bus.req_readdata), 64'(0));
            chk("rst_mid_err", 64'(err_sticky), 64'(0));
            model_reset();
            act = '0;
            bus.req_read = '0;
            bus.req_write = '0;
            @(negedge clk);
            rst = 1'b0;
            force_read = 1'b0;
            for (int i = 0; i < N; i++) new_cmd(i);
            step();
            step();
            chk("rst_first_grant", 64'(grant_id), 64'(0));
        end

        force_read = 1'b0;
        repeat (800) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
